lzw_decoder: RTL

LZW decompression core: accepts the 12-bit code stream produced by the compressor datapath and emits the reconstructed 8-bit character stream. It rebuilds the dictionary on the fly as (prefix code, suffix char) pairs, walks each code's chain into a LIFO stack, and pops the characters out in order. It sits between the code-input buffer and the byte-output buffer, with valid/ready handshakes on both sides.

---
 rtl/lzw_pkg.sv | 22 ++
 rtl/lzw_dict_ram.sv | 28 ++
 rtl/lzw_decoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lzw_pkg.sv
// Shared LZW definitions: code/char widths, reserved code range, decoder states
// and the dictionary entry layout used by both compressor and decompressor.
package lzw_pkg;

    localparam int unsigned CODE_W          = 12;
    localparam int unsigned CHAR_W          = 8;
    localparam int unsigned FIRST_FREE_CODE = 256;
    localparam int unsigned MAX_CODE        = 4095;

    typedef enum logic [1:0] {
        StIdle,
        StWalk,
        StFetch,
        StEmit
    } lzw_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] prefix;
        logic [CHAR_W-1:0] suffix;
    } dict_entry_t;

endpackage

// File: rtl/lzw_dict_ram.sv
// LZW dictionary: 2^CODE_W entries of {prefix, suffix}, one synchronous read
// port (1-cycle latency) and one write port.
module lzw_dict_ram
    import lzw_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [CODE_W-1:0] waddr_i,
    input  dict_entry_t       wdata_i,
    input  logic [CODE_W-1:0] raddr_i,
    output dict_entry_t       rdata_o
);

    localparam int unsigned Depth = 1 << CODE_W;

    dict_entry_t mem_q [Depth];
    dict_entry_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lzw_decoder.sv
// LZW decompression core: rebuilds the dictionary from the code stream, walks
// each code's prefix chain onto a LIFO and pops the characters out in order.
module lzw_decoder
    import lzw_pkg::*;
#(
    parameter int unsigned StackDepth = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_clear_i,
    input  logic [CODE_W-1:0] in_code_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [CHAR_W-1:0] out_char_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CODE_W-1:0] next_code_o,
    output logic              dict_full_o,
    output logic              error_o,
    output logic              busy_o
);

    localparam int unsigned       SpW       = $clog2(StackDepth + 1);
    localparam int unsigned       IdxW      = $clog2(StackDepth);
    localparam logic [CODE_W-1:0] FirstFree = CODE_W'(FIRST_FREE_CODE);
    localparam logic [CODE_W-1:0] MaxCode   = CODE_W'(MAX_CODE);
    localparam logic [SpW-1:0]    SpFull    = SpW'(StackDepth);
    localparam logic [SpW-1:0]    SpOne     = SpW'(1);
    localparam logic [SpW-1:0]    SpTwo     = SpW'(2);

    lzw_state_e        state_q;
    logic [CODE_W-1:0] cur_q, prev_code_q, acc_code_q, next_code_q;
    logic              prev_valid_q, dict_full_q, error_q;
    logic [CHAR_W-1:0] first_char_q, out_char_q;
    logic              out_valid_q;
    logic [SpW-1:0]    sp_q;
    logic [CHAR_W-1:0] stack_q [StackDepth];

    logic              accept, code_known, kwkwk, stack_full, last_pop, dict_we;
    logic              push_en;
    logic [CHAR_W-1:0] push_data;
    logic [SpW-1:0]    sp_top, sp_below;
    dict_entry_t       rd_entry, wr_entry;

    assign accept     = (state_q == StIdle) && in_valid_i && !error_q;
    assign code_known = (in_code_i < next_code_q) || dict_full_q;
    assign kwkwk      = (in_code_i == next_code_q) && prev_valid_q && !dict_full_q;
    assign stack_full = (sp_q == SpFull);
    assign sp_top     = sp_q - SpOne;
    assign sp_below   = sp_q - SpTwo;
    assign last_pop   = (state_q == StEmit) && out_valid_q && out_ready_i && (sp_q == SpOne);
    assign dict_we    = last_pop && prev_valid_q && !dict_full_q && !in_clear_i;
    assign wr_entry   = '{prefix: prev_code_q, suffix: first_char_q};

    lzw_dict_ram u_dict (
        .clk_i   (clk_i),
        .we_i    (dict_we),
        .waddr_i (next_code_q),
        .wdata_i (wr_entry),
        .raddr_i (cur_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        push_en   = 1'b0;
        push_data = '0;
        unique case (state_q)
            StIdle: begin
                if (accept && !code_known && kwkwk) begin
                    push_en   = 1'b1;
                    push_data = first_char_q;
                end
            end
            StWalk: begin
                if (cur_q < FirstFree) begin
                    push_en   = 1'b1;
                    push_data = cur_q[CHAR_W-1:0];
                end
            end
            StFetch: begin
                push_en   = 1'b1;
                push_data = rd_entry.suffix;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_en && !stack_full) begin
            stack_q[sp_q[IdxW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            prev_code_q  <= '0;
            acc_code_q   <= '0;
            next_code_q  <= FirstFree;
            prev_valid_q <= 1'b0;
            dict_full_q  <= 1'b0;
            error_q      <= 1'b0;
            first_char_q <= '0;
            out_char_q   <= '0;
            out_valid_q  <= 1'b0;
            sp_q         <= '0;
        end else if (in_clear_i) begin
            state_q      <= StIdle;
            next_code_q  <= FirstFree;
            prev_valid_q <= 1'b0;
            dict_full_q  <= 1'b0;
            error_q      <= 1'b0;
            out_char_q   <= '0;
            out_valid_q  <= 1'b0;
            sp_q         <= '0;
        end else if (push_en && stack_full) begin
            // Overflow: the string is longer than the stack, abandon it.
            state_q     <= StIdle;
            error_q     <= 1'b1;
            out_char_q  <= '0;
            out_valid_q <= 1'b0;
            sp_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        acc_code_q <= in_code_i;
                        if (code_known) begin
                            cur_q   <= in_code_i;
                            state_q <= StWalk;
                        end else if (kwkwk) begin
                            sp_q    <= sp_q + SpOne;
                            cur_q   <= prev_code_q;
                            state_q <= StWalk;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StWalk: begin
                    if (cur_q < FirstFree) begin
                        sp_q         <= sp_q + SpOne;
                        first_char_q <= cur_q[CHAR_W-1:0];
                        state_q      <= StEmit;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    sp_q    <= sp_q + SpOne;
                    cur_q   <= rd_entry.prefix;
                    state_q <= StWalk;
                end
                StEmit: begin
                    // First EMIT cycle only loads the output flops from the stack top.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_char_q  <= stack_q[sp_top[IdxW-1:0]];
                    end else if (out_ready_i) begin
                        if (sp_q == SpOne) begin
                            sp_q         <= '0;
                            out_valid_q  <= 1'b0;
                            out_char_q   <= '0;
                            prev_code_q  <= acc_code_q;
                            prev_valid_q <= 1'b1;
                            state_q      <= StIdle;
                            if (prev_valid_q && !dict_full_q) begin
                                if (next_code_q == MaxCode) begin
                                    dict_full_q <= 1'b1;
                                end else begin
                                    next_code_q <= next_code_q + CODE_W'(1);
                                end
                            end
                        end else begin
                            sp_q       <= sp_q - SpOne;
                            out_char_q <= stack_q[sp_below[IdxW-1:0]];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign out_char_o  = out_char_q;
    assign out_valid_o = out_valid_q;
    assign next_code_o = next_code_q;
    assign dict_full_o = dict_full_q;
    assign error_o     = error_q;

endmodule
